ps2_key_collector: RTL

- Upstream front end of the keyboard-driven mode fsm.
- Receives raw PS/2 keyboard frames and discards break (key-release) sequences and extended prefixes.
- Shifts each accepted make code into a 9-byte history register.
- The mode fsm slices this history for its command match (init [15:0], alu [31:0], bench [31:0], isa [71:0]) and watches byte [7:0] for enter (5A) and run (2D).

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_key_collector_if.sv | 23 ++
 rtl/ps2_clk_filter.sv | 52 +++++
 rtl/ps2_key_collector.sv | 136 +++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants and frame-state encoding for the key collector
// and the downstream mode FSM.
package ps2_pkg;
  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_I     = 8'h43;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_B     = 8'h32;
  localparam logic [7:0] KEY_R     = 8'h2D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

  // Odd parity over data+parity bit and a high stop bit.
  function automatic logic frame_ok(input logic [7:0] b, input logic par, input logic stop);
    return (^{b, par}) & stop;
  endfunction
endpackage

// File: rtl/ps2_key_collector_if.sv
// Keyboard pins, history clear and decoded-key outputs of the PS/2 key collector.
interface ps2_key_collector_if #(
  parameter int unsigned HIST_BYTES = 9
);
  logic                    ps2_clk;
  logic                    ps2_data;
  logic                    hist_clear;
  logic                    key_valid;
  logic [7:0]              key_code;
  logic [8*HIST_BYTES-1:0] key_history;
  logic                    frame_err;
  logic                    busy;

  modport master (
    output ps2_clk, ps2_data, hist_clear,
    input  key_valid, key_code, key_history, frame_err, busy
  );

  modport slave (
    input  ps2_clk, ps2_data, hist_clear,
    output key_valid, key_code, key_history, frame_err, busy
  );
endinterface

// File: rtl/ps2_clk_filter.sv
// Synchronizes the PS/2 pins, debounces the clock and emits a one-cycle fall pulse
// together with the data level sampled on that cycle.
module ps2_clk_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data
);
  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall_q, fall_d;
  logic          data_q;

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
      else                              cnt_d  = cnt_q + 1'b1;
    end
    fall_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      fall_q      <= 1'b0;
      data_q      <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      fall_q      <= fall_d;
      data_q      <= data_sync_q[1];
    end
  end

  assign fall = fall_q;
  assign data = data_q;
endmodule

// File: rtl/ps2_key_collector.sv
// PS/2 frame receiver: drops break sequences and E0 prefixes, delivers make codes
// and keeps a newest-first make-code history for the mode FSM.
module ps2_key_collector
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned HIST_BYTES     = 9
) (
  input logic               clk,
  input logic               rst,
  ps2_key_collector_if.slave bus
);
  localparam int unsigned HW = 8 * HIST_BYTES;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic fall, ps2_data_s;

  frame_state_e  state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          break_q, break_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          key_valid_q, key_valid_d;
  logic [7:0]    key_code_q, key_code_d;
  logic [HW-1:0] hist_q, hist_d, hist_base;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (bus.ps2_clk),
    .ps2_data (bus.ps2_data),
    .fall     (fall),
    .data     (ps2_data_s)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    break_d     = break_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    frame_err_d = 1'b0;
    hist_base   = bus.hist_clear ? '0 : hist_q;
    hist_d      = hist_base;
    tmo_d       = tmo_q;

    if (fall)                    tmo_d = '0;
    else if (state_q != ST_IDLE) tmo_d = tmo_q + 1'b1;

    if (!fall && state_q != ST_IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      break_d     = 1'b0;
      tmo_d       = '0;
    end else if (fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!ps2_data_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {ps2_data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = ps2_data_s;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!frame_ok(shift_q, parity_q, ps2_data_s)) begin
            frame_err_d = 1'b1;
            break_d     = 1'b0;
          end else if (shift_q == KEY_BREAK) begin
            break_d = 1'b1;
          end else if (shift_q == KEY_EXT) begin
            // Prefix only: the following base code is delivered unchanged.
            break_d = break_q;
          end else if (break_q) begin
            break_d = 1'b0;
          end else begin
            key_valid_d = 1'b1;
            key_code_d  = shift_q;
            hist_d      = {hist_base[HW-9:0], shift_q};
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      break_q     <= 1'b0;
      tmo_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      hist_q      <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      break_q     <= break_d;
      tmo_q       <= tmo_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      hist_q      <= hist_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.key_valid   = key_valid_q;
  assign bus.key_code    = key_code_q;
  assign bus.key_history = hist_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.busy        = busy_q;
endmodule
